imm_extend_stage: RTL and testbench
===================================

IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, meaning the width of the short immediate field.
REQ-002 The block SHALL have parameter JMP_W, default 26, meaning the width of the jump target field (JMP_W >= IN_W).
REQ-003 The block SHALL have parameter OUT_W, default 32, meaning the output word width (OUT_W >= JMP_W+2 and OUT_W >= 2*IN_W).
REQ-004 The block SHALL have parameter TAG_W, default 5, meaning the width of the opaque sideband tag, e.g. destination register.
REQ-005 The block SHALL have one clock and a synchronous active-high reset, with these ports (clock and reset first):
  - clock  in  1  sole clock, rising edge.
  - reset  in  1  synchronous, active-high.
  - flush  in  1  discard all held entries (pipeline squash).
  - in_valid  in  1  upstream entry present.
  - in_ready  out  1  block can accept an entry this cycle.
  - in_mode  in  3  extension mode.
  - in_imm  in  JMP_W  raw immediate; bits above IN_W-1 used only by JUMP.
  - in_tag  in  TAG_W  sideband, passed through unchanged.
  - out_valid  out  1  output entry present.
  - out_ready  in  1  downstream accepts the entry.
  - out_data  out  OUT_W  extended immediate.
  - out_tag  out  TAG_W  tag of the output entry.
  - out_illegal  out  1  entry carried a reserved mode.

Function
REQ-006 Modes SHALL be encoded as follows:
  - SIGN=0: replicate in_imm[IN_W-1] above in_imm[IN_W-1:0].
  - ZERO=1: zero-fill above in_imm[IN_W-1:0].
  - LUI=2: in_imm[IN_W-1:0] placed at bits [2*IN_W-1:IN_W], low IN_W bits 0, upper bits 0.
  - BRANCH=3: SIGN result shifted left 2, bits above OUT_W-1 dropped.
  - JUMP=4: zero-extended {in_imm[JMP_W-1:0], 2'b00}.
REQ-007 Modes 5-7 SHALL produce out_data=0 and out_illegal=1; every other mode SHALL produce out_illegal=0.
REQ-008 An input transfer SHALL occur when in_valid&&in_ready; an output transfer SHALL occur when out_valid&&out_ready.
REQ-009 Latency SHALL be exactly 1 cycle when unstalled: an entry accepted at edge N is presented on the outputs after edge N.
REQ-010 Computation SHALL occur at input time, and registered out_data/out_tag/out_illegal SHALL hold stable while out_valid&&!out_ready.
REQ-011 Storage SHALL be an output register plus one skid register (capacity 2), and in_ready SHALL be the registered value !skid_full, with no combinational path from out_ready.
REQ-012 When the output register is empty or transferring, it SHALL load from the skid register if that is full, otherwise from the input.
REQ-013 When the output is stalled and an input transfer occurs, the entry SHALL go to the skid register.
REQ-014 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-015 A simultaneous input and output transfer with the skid register empty SHALL keep out_valid=1 and replace the output contents.
REQ-016 On flush, the next cycle SHALL have out_valid=0, skid empty and in_ready=1; an input offered in the flush cycle SHALL be discarded; flush SHALL override any simultaneous transfer.
REQ-017 Data outputs SHALL be don't-care while out_valid=0, but the bench SHALL check them only when valid.

Reset
REQ-018 While reset=1 at a rising edge, the block SHALL set out_valid=0, skid empty, in_ready=1, out_data=0, out_tag=0 and out_illegal=0.
REQ-019 Reset SHALL take priority over flush and all transfers.
REQ-020 Entries held when reset is asserted mid-operation SHALL be lost.
REQ-021 The block SHALL hold no other state.

Structure
REQ-022 The mode encodings (SIGN..JUMP) and the MODE_W=3 constant SHALL reside in the shared package imm_ext_pkg, for use by the decoder.
REQ-023 The pure mode-to-word function SHALL be the combinational sub-module imm_ext_core (params IN_W, JMP_W, OUT_W), instantiated once on the input path.
REQ-024 The handshake and storage logic SHALL reside in imm_extend_stage itself.

Verification
REQ-025 Mode sweep, out_ready=1, defaults: SIGN 0x8000 -> 0xFFFF8000; ZERO 0x8000 -> 0x00008000; LUI 0x1234 -> 0x12340000; BRANCH 0xFFFF -> 0xFFFFFFFC; JUMP 0x3FFFFFF -> 0x0FFFFFFC; each one cycle after acceptance.
REQ-026 Reserved mode 5 with imm 0x7FFF, tag 3 -> out_data=0, out_illegal=1, out_tag=3.
REQ-027 Backpressure: hold out_ready=0, push tags 1,2,3 back-to-back -> tags 1 and 2 accepted, in_ready=0 from the next cycle, tag 3 held upstream; release out_ready -> tags 1,2,3 delivered in order, no gaps once streaming.
REQ-028 Flush with both registers full plus in_valid=1 in the flush cycle -> next cycle out_valid=0, in_ready=1, and none of the three entries ever appears.
REQ-029 Reset asserted mid-stall with 2 entries held -> next cycle all outputs are 0 and in_ready=1; a post-reset entry SIGN 0x0001 -> 0x00000001.
REQ-030 Parameter run with IN_W=8, JMP_W=12, OUT_W=16: SIGN 0x80 -> 0xFF80; LUI 0xAB -> 0xAB00; JUMP 0xFFF -> 0x3FFC.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared immediate-extension mode encodings and helpers
package imm_ext_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_SIGN   = 3'd0,
        MODE_ZERO   = 3'd1,
        MODE_LUI    = 3'd2,
        MODE_BRANCH = 3'd3,
        MODE_JUMP   = 3'd4
    } imm_mode_e;

    // Encodings 5..7 are reserved and flagged as illegal by the extender.
    function automatic logic mode_is_reserved(input logic [MODE_W-1:0] mode);
        return mode > MODE_JUMP;
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational mode-to-word immediate extender
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int JMP_W = 26,
    parameter int OUT_W = 32
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [JMP_W-1:0]  imm,
    output logic [OUT_W-1:0]  data,
    output logic              illegal
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] lui;
    logic [OUT_W-1:0] branch;
    logic [OUT_W-1:0] jump;

    always_comb begin
        sext                = {OUT_W{imm[IN_W-1]}};
        sext[IN_W-1:0]      = imm[IN_W-1:0];
        zext                = '0;
        zext[IN_W-1:0]      = imm[IN_W-1:0];
        lui                 = '0;
        lui[2*IN_W-1:IN_W]  = imm[IN_W-1:0];
        branch              = sext << 2;
        jump                = '0;
        jump[JMP_W+1:0]     = {imm, 2'b00};
    end

    always_comb begin
        data    = '0;
        illegal = mode_is_reserved(mode);
        case (mode)
            MODE_SIGN:   data = sext;
            MODE_ZERO:   data = zext;
            MODE_LUI:    data = lui;
            MODE_BRANCH: data = branch;
            MODE_JUMP:   data = jump;
            default:     data = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// rtl/imm_extend_stage.sv - registered immediate extender with output + skid buffering
module imm_extend_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int JMP_W = 26,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [JMP_W-1:0]  in_imm,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal
);

    logic [OUT_W-1:0] core_data;
    logic             core_illegal;

    logic             skid_full;
    logic [OUT_W-1:0] skid_data;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_illegal;

    logic             in_xfer;
    logic             load_out;

    imm_ext_core #(
        .IN_W  (IN_W),
        .JMP_W (JMP_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode    (in_mode),
        .imm     (in_imm),
        .data    (core_data),
        .illegal (core_illegal)
    );

    // Ready depends only on registered skid state, so out_ready never reaches in_ready.
    assign in_ready = !skid_full;
    assign in_xfer  = in_valid && in_ready;
    assign load_out = !out_valid || out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_tag      <= '0;
            out_illegal  <= 1'b0;
            skid_full    <= 1'b0;
            skid_data    <= '0;
            skid_tag     <= '0;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (load_out) begin
            // Skid holds the older entry, so it drains before any new input.
            if (skid_full) begin
                out_valid   <= 1'b1;
                out_data    <= skid_data;
                out_tag     <= skid_tag;
                out_illegal <= skid_illegal;
                skid_full   <= 1'b0;
            end else if (in_xfer) begin
                out_valid   <= 1'b1;
                out_data    <= core_data;
                out_tag     <= in_tag;
                out_illegal <= core_illegal;
            end else begin
                out_valid   <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_full    <= 1'b1;
            skid_data    <= core_data;
            skid_tag     <= in_tag;
            skid_illegal <= core_illegal;
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// tb/tb_imm_extend_stage.sv - randomized scoreboard bench for imm_extend_stage
module tb_imm_extend_stage;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        ill;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [2:0]  in_mode;
    logic [25:0] in_imm;
    logic [4:0]  in_tag;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    logic        p_in_valid, p_out_ready;
    logic [2:0]  p_in_mode;
    logic [11:0] p_in_imm;
    logic [4:0]  p_in_tag;
    logic        p_in_ready, p_out_valid, p_out_illegal;
    logic [15:0] p_out_data;
    logic [4:0]  p_out_tag;

    int n_vec = 0;
    int n_bad = 0;
    ent_t q[$];
    ent_t pq[$];

    always #5 clock = ~clock;

    imm_extend_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_imm(in_imm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    imm_extend_stage #(.IN_W(8), .JMP_W(12), .OUT_W(16), .TAG_W(5)) dut_p (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_mode(p_in_mode),
        .in_imm(p_in_imm), .in_tag(p_in_tag),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .out_tag(p_out_tag), .out_illegal(p_out_illegal)
    );

    function automatic ent_t ref_ent(input int in_w, input int jmp_w, input int out_w,
                                     input int mode, input longint unsigned imm, input int tag);
        longint unsigned low, full, omod, sx;
        ent_t e;
        low  = imm % (64'd1 << in_w);
        full = imm % (64'd1 << jmp_w);
        omod = 64'd1 << out_w;
        sx   = (low >= (64'd1 << (in_w - 1))) ? low + omod - (64'd1 << in_w) : low;
        e.ill = 1'b0;
        e.tag = tag[4:0];
        case (mode)
            0:       e.data = sx;
            1:       e.data = low;
            2:       e.data = low * (64'd1 << in_w);
            3:       e.data = (sx * 4) % omod;
            4:       e.data = full * 4;
            default: begin e.data = 0; e.ill = 1'b1; end
        endcase
        e.data = e.data % omod;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        if (q.size() > 0 && out_valid) begin
            check("out_data", {32'd0, out_data}, q[0].data);
            check("out_tag", {59'd0, out_tag}, {59'd0, q[0].tag});
            check("out_illegal", {63'd0, out_illegal}, {63'd0, q[0].ill});
        end
        check("p_in_ready", {63'd0, p_in_ready}, {63'd0, pq.size() < 2});
        check("p_out_valid", {63'd0, p_out_valid}, {63'd0, pq.size() > 0});
        if (pq.size() > 0 && p_out_valid) begin
            check("p_out_data", {48'd0, p_out_data}, pq[0].data);
            check("p_out_tag", {59'd0, p_out_tag}, {59'd0, pq[0].tag});
            check("p_out_illegal", {63'd0, p_out_illegal}, {63'd0, pq[0].ill});
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic v, input int mode,
                        input longint unsigned imm, input int tag, input logic ordy);
        bit rdy, prdy;
        reset = rst; flush = fl; in_valid = v; out_ready = ordy;
        in_mode = mode[2:0]; in_imm = imm[25:0]; in_tag = tag[4:0];
        if (rst || fl) begin
            q.delete();
            pq.delete();
        end else begin
            rdy  = q.size() < 2;
            prdy = pq.size() < 2;
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && rdy) q.push_back(ref_ent(16, 26, 32, mode, imm, tag));
            if (pq.size() > 0 && p_out_ready) void'(pq.pop_front());
            if (p_in_valid && prdy)
                pq.push_back(ref_ent(8, 12, 16, int'(p_in_mode), longint'(p_in_imm), int'(p_in_tag)));
        end
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    endtask

    initial begin
        p_in_valid = 1'b0; p_out_ready = 1'b1; p_in_mode = '0; p_in_imm = '0; p_in_tag = '0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_mode = '0; in_imm = '0; in_tag = '0;

        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 0, 'h1234, 7, 1'b1);
        check("rst_data", {32'd0, out_data}, 64'd0);
        check("rst_tag", {59'd0, out_tag}, 64'd0);
        check("rst_illegal", {63'd0, out_illegal}, 64'd0);

        step(1'b0, 1'b0, 1'b1, 0, 'h8000, 1, 1'b1);
        check("sweep_sign", {32'd0, out_data}, 64'hFFFF8000);
        step(1'b0, 1'b0, 1'b1, 1, 'h8000, 2, 1'b1);
        check("sweep_zero", {32'd0, out_data}, 64'h00008000);
        step(1'b0, 1'b0, 1'b1, 2, 'h1234, 3, 1'b1);
        check("sweep_lui", {32'd0, out_data}, 64'h12340000);
        step(1'b0, 1'b0, 1'b1, 3, 'hFFFF, 4, 1'b1);
        check("sweep_branch", {32'd0, out_data}, 64'hFFFFFFFC);
        step(1'b0, 1'b0, 1'b1, 4, 'h3FFFFFF, 5, 1'b1);
        check("sweep_jump", {32'd0, out_data}, 64'h0FFFFFFC);
        step(1'b0, 1'b0, 1'b1, 5, 'h7FFF, 3, 1'b1);
        check("rsv_data", {32'd0, out_data}, 64'd0);
        check("rsv_illegal", {63'd0, out_illegal}, 64'd1);
        check("rsv_tag", {59'd0, out_tag}, 64'd3);
        idle(2);

        step(1'b0, 1'b0, 1'b1, 0, 'h11, 1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 'h22, 2, 1'b0);
        check("bp_full_rdy", {63'd0, in_ready}, 64'd0);
        step(1'b0, 1'b0, 1'b1, 0, 'h33, 3, 1'b0);
        check("bp_hold_tag", {59'd0, out_tag}, 64'd1);
        step(1'b0, 1'b0, 1'b1, 0, 'h33, 3, 1'b1);
        check("bp_tag2", {59'd0, out_tag}, 64'd2);
        step(1'b0, 1'b0, 1'b1, 0, 'h33, 3, 1'b1);
        check("bp_tag3", {59'd0, out_tag}, 64'd3);
        check("bp_valid3", {63'd0, out_valid}, 64'd1);
        idle(2);

        step(1'b0, 1'b0, 1'b1, 1, 'h41, 10, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1, 'h42, 11, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1, 'h43, 12, 1'b0);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_rdy", {63'd0, in_ready}, 64'd1);
        idle(3);

        step(1'b0, 1'b0, 1'b1, 2, 'h51, 13, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2, 'h52, 14, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_data", {32'd0, out_data}, 64'd0);
        check("mid_rst_tag", {59'd0, out_tag}, 64'd0);
        check("mid_rst_rdy", {63'd0, in_ready}, 64'd1);
        step(1'b0, 1'b0, 1'b1, 0, 'h0001, 6, 1'b1);
        check("post_rst_sign", {32'd0, out_data}, 64'h00000001);
        idle(1);

        p_in_valid = 1'b1; p_in_mode = 3'd0; p_in_imm = 12'h080; p_in_tag = 5'd1;
        idle(1);
        check("p_sign", {48'd0, p_out_data}, 64'hFF80);
        p_in_mode = 3'd2; p_in_imm = 12'h0AB; p_in_tag = 5'd2;
        idle(1);
        check("p_lui", {48'd0, p_out_data}, 64'hAB00);
        p_in_mode = 3'd4; p_in_imm = 12'hFFF; p_in_tag = 5'd3;
        idle(1);
        check("p_jump", {48'd0, p_out_data}, 64'h3FFC);
        p_in_valid = 1'b0;
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            p_in_valid  = ($urandom_range(0, 9) < 6);
            p_in_mode   = 3'($urandom_range(0, 7));
            p_in_imm    = 12'($urandom);
            p_in_tag    = 5'($urandom);
            p_out_ready = ($urandom_range(0, 9) < 6);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
                 longint'($urandom), int'($urandom_range(0, 31)),
                 $urandom_range(0, 9) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
